// File: rtl/bcd_display_mux.sv
// Two-digit BCD to common-anode seven-segment multiplexer with per-frame snapshot.
// Optional build macro LEAD_ZERO_BLANK_EN blanks the tens slot when the tens digit is 0.
module bcd_display_mux #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] q1,
  input  logic [3:0] q10,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic {ONES, TENS} digit_t;

  digit_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_s1, r_s10;
  logic          r_first;
  logic          w_tc, w_load;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign w_tc   = en && (r_cnt == LAST);
  // Snapshot only at the frame boundary (end of TENS) or on the first enabled cycle.
  assign w_load = en && (r_first || (w_tc && (r_state == TENS)));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ONES;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tc) w_state_nxt = (r_state == ONES) ? TENS : ONES;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_s1    <= '0;
      r_s10   <= '0;
      r_first <= 1'b1;
    end else begin
      if (en) r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
      if (w_load) begin
        r_s1    <= q1;
        r_s10   <= q10;
        r_first <= 1'b0;
      end
    end
  end

  // First cycle of each slot (cnt==0) is the anti-ghosting blank.
  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = '1;
    if (en && (r_cnt != '0)) begin
      if (r_state == ONES) begin
        w_an_nxt  = 4'b1110;
        w_seg_nxt = decode(r_s1);
      end else begin
`ifdef LEAD_ZERO_BLANK_EN
        if (r_s10 != 4'd0) begin
          w_an_nxt  = 4'b1101;
          w_seg_nxt = decode(r_s10);
        end
`else
        w_an_nxt  = 4'b1101;
        w_seg_nxt = decode(r_s10);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= '1;
    end else begin
      an  <= w_an_nxt;
      seg <= w_seg_nxt;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Self-checking bench for bcd_display_mux: table vectors, corner sequences and a
// randomized run against a frame-position reference model.
module tb_bcd_display_mux;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] q1  = '0;
  logic [3:0] q10 = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int vectors    = 0;
  int miscompares = 0;

  bcd_display_mux #(.REFRESH_DIV(N)) dut (
    .clk(clk), .rst(rst), .en(en), .q1(q1), .q10(q10),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  // Reference model: position within a 2N-clock frame plus the frame snapshot.
  int         m_pos   = 0;
  logic [3:0] m_s1    = '0;
  logic [3:0] m_s10   = '0;
  bit         m_first = 1'b1;
  logic [6:0] seg_tab [16];

  typedef struct {
    logic [3:0] q1;
    logic [3:0] q10;
    logic [6:0] ones_seg;
    logic [3:0] tens_an;
    logic [6:0] tens_seg;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [6:0] es;
    logic [3:0] ea;
    int slot, off;
    es = '1;
    ea = '1;
    if (!rst && en) begin
      slot = m_pos / N;
      off  = m_pos % N;
      if (off != 0) begin
        if (slot == 0) begin
          ea = 4'b1110;
          es = seg_tab[m_s1];
        end else begin
`ifdef LEAD_ZERO_BLANK_EN
          if (m_s10 != 4'd0) begin
`else
          begin
`endif
            ea = 4'b1101;
            es = seg_tab[m_s10];
          end
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      m_pos = 0; m_s1 = '0; m_s10 = '0; m_first = 1'b1;
    end else if (en) begin
      if (m_first || m_pos == 2 * N - 1) begin
        m_s1 = q1; m_s10 = q10; m_first = 1'b0;
      end
      m_pos = (m_pos + 1) % (2 * N);
    end
    #1;
    check("model_seg", seg, es);
    check("model_an", {3'b0, an}, {3'b0, ea});
    check("dp", {6'b0, dp}, 7'h01);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  initial begin
    int ones_cnt;
    bit saw_tens;
    int unsigned r;

    for (int i = 0; i < 16; i++) seg_tab[i] = 7'b0111111;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    tbl[0] = '{4'd3, 4'd7, 7'b0110000, 4'b1101, 7'b1111000};
    tbl[1] = '{4'hC, 4'hF, 7'b0111111, 4'b1101, 7'b0111111};
`ifdef LEAD_ZERO_BLANK_EN
    tbl[2] = '{4'd8, 4'd0, 7'b0000000, 4'b1111, 7'b1111111};
    tbl[3] = '{4'd0, 4'd0, 7'b1000000, 4'b1111, 7'b1111111};
`else
    tbl[2] = '{4'd8, 4'd0, 7'b0000000, 4'b1101, 7'b1000000};
    tbl[3] = '{4'd0, 4'd0, 7'b1000000, 4'b1101, 7'b1000000};
`endif
    tbl[4] = '{4'd9, 4'd6, 7'b0010000, 4'b1101, 7'b0000010};

    #2;
    en = 1'b1;
    do_reset();
    check("reset_an", {3'b0, an}, 7'b0001111);
    check("reset_seg", seg, 7'b1111111);

    // Table vectors: edge 1 blank, edges 2-4 ONES, edge 5 blank, edges 6-8 TENS.
    foreach (tbl[k]) begin
      q1 = tbl[k].q1; q10 = tbl[k].q10;
      do_reset();
      step();
      check("tbl_first_blank", {3'b0, an}, 7'b0001111);
      step();
      check("tbl_ones_an", {3'b0, an}, 7'b0001110);
      check("tbl_ones_seg", seg, tbl[k].ones_seg);
      steps(3);
      check("tbl_slot_blank", {3'b0, an}, 7'b0001111);
      step();
      check("tbl_tens_an", {3'b0, an}, {3'b0, tbl[k].tens_an});
      check("tbl_tens_seg", seg, tbl[k].tens_seg);
      steps(2);
    end

    // q1 changes mid-TENS: current frame unaffected, new value from edge 10.
    q1 = 4'd3; q10 = 4'd7;
    do_reset();
    steps(6);
    q1 = 4'd5;
    steps(2);
    check("midframe_tens_seg", seg, 7'b1111000);
    step();
    check("boundary_blank_an", {3'b0, an}, 7'b0001111);
    step();
    check("new_ones_seg", seg, 7'b0010010);
    check("new_ones_an", {3'b0, an}, 7'b0001110);

    // en dropped for 10 cycles mid-ONES slot.
    q1 = 4'd3; q10 = 4'd7;
    do_reset();
    steps(2);
    ones_cnt = (an == 4'b1110) ? 1 : 0;
    en = 1'b0;
    step();
    check("en_off_an", {3'b0, an}, 7'b0001111);
    check("en_off_seg", seg, 7'b1111111);
    steps(9);
    en = 1'b1;
    saw_tens = 1'b0;
    for (int i = 0; i < 20 && !saw_tens; i++) begin
      step();
      if (an == 4'b1110) ones_cnt++;
      if (an == 4'b1101) saw_tens = 1'b1;
    end
    check("en_resume_reached_tens", {6'b0, saw_tens}, 7'd1);
    check("en_resume_ones_cycles", 7'(ones_cnt), 7'd3);

    // One-cycle reset pulse during TENS restarts with a fresh snapshot.
    q1 = 4'd3; q10 = 4'd7;
    do_reset();
    steps(6);
    q1 = 4'd9;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_pulse_an", {3'b0, an}, 7'b0001111);
    check("rst_pulse_seg", seg, 7'b1111111);
    step();
    check("rst_restart_blank", {3'b0, an}, 7'b0001111);
    step();
    check("rst_restart_an", {3'b0, an}, 7'b0001110);
    check("rst_restart_seg", seg, 7'b0010000);

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom;
      rst = (r % 151) == 0;
      en  = (r[15:8] % 10) != 0;
      if (r[19:17] == 3'd0) q1  = 4'($urandom_range(15, 0));
      if (r[22:20] == 3'd0) q10 = 4'($urandom_range(15, 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
